// File: rtl/sdram_init_chk.sv
// Passive checker for the SDRAM power-up command sequence.
// Decodes the command bus, times command spacing and reports the first violation.
module sdram_init_chk #(
  parameter int WAIT_MIN = 20000,
  parameter int TRP_MIN  = 2,
  parameter int TRFC_MIN = 7,
  parameter int TMRD_MIN = 2,
  parameter int AREF_MIN = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [3:0]  sdram_cmd,
  input  logic [1:0]  sdram_ba,
  input  logic [12:0] sdram_addr,
  output logic        init_done,
  output logic        init_err,
  output logic [2:0]  err_code,
  output logic [12:0] mode_reg,
  output logic [2:0]  cas_lat,
  output logic [3:0]  burst_len,
  output logic [3:0]  aref_cnt
);

  typedef enum logic [2:0] {S_WAIT, S_TRP, S_AREF, S_TMRD, S_DONE, S_ERR} state_t;
  typedef enum logic [2:0] {C_NOP, C_PRE, C_AREF, C_MRS, C_OTHER} cmd_t;

  localparam logic [2:0] E_EARLY = 3'd1;
  localparam logic [2:0] E_ORDER = 3'd2;
  localparam logic [2:0] E_TRP   = 3'd3;
  localparam logic [2:0] E_TRFC  = 3'd4;
  localparam logic [2:0] E_ACNT  = 3'd5;
  localparam logic [2:0] E_FIELD = 3'd6;
  localparam logic [2:0] E_TMRD  = 3'd7;

  localparam logic [15:0] WAIT_MIN_C = 16'(WAIT_MIN);
  localparam logic [15:0] TRP_MIN_C  = 16'(TRP_MIN);
  localparam logic [15:0] TRFC_MIN_C = 16'(TRFC_MIN);
  localparam logic [15:0] TMRD_MIN_C = 16'(TMRD_MIN);
  localparam logic [3:0]  AREF_MIN_C = 4'(AREF_MIN);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic        init_done_reg, init_done_next;
  logic        init_err_reg, init_err_next;
  logic [2:0]  err_code_reg, err_code_next;
  logic [12:0] mode_reg_reg, mode_reg_next;
  logic [2:0]  cas_lat_reg, cas_lat_next;
  logic [3:0]  burst_len_reg, burst_len_next;
  logic [3:0]  aref_cnt_reg, aref_cnt_next;

  cmd_t        cmd_kind;
  logic        is_cmd;
  logic        cas_ok, bl_ok, mrs_ok;
  logic        fail;
  logic [2:0]  fail_code;

  function automatic logic [3:0] burst_decode(input logic [2:0] code);
    case (code)
      3'b000:  return 4'd1;
      3'b001:  return 4'd2;
      3'b010:  return 4'd4;
      3'b011:  return 4'd8;
      default: return 4'd15;
    endcase
  endfunction

  always_comb begin
    cmd_kind = C_OTHER;
    if (sdram_cmd[3] || sdram_cmd == 4'b0111) begin
      cmd_kind = C_NOP;
    end else begin
      case (sdram_cmd)
        4'b0010: cmd_kind = C_PRE;
        4'b0001: cmd_kind = C_AREF;
        4'b0000: cmd_kind = C_MRS;
        default: cmd_kind = C_OTHER;
      endcase
    end
  end

  assign is_cmd = (cmd_kind != C_NOP);

  // Only CAS 2/3 and sequential burst lengths are supported; full page needs sequential type.
  assign cas_ok = (sdram_addr[6:4] == 3'b010) || (sdram_addr[6:4] == 3'b011);
  assign bl_ok  = (sdram_addr[2] == 1'b0) || (sdram_addr[2:0] == 3'b111 && !sdram_addr[3]);
  assign mrs_ok = (sdram_ba == 2'b00) && (sdram_addr[12:10] == 3'b000) &&
                  (sdram_addr[8:7] == 2'b00) && cas_ok && bl_ok;

  // Distance counter: reads as command-to-command spacing when the next command arrives.
  always_comb begin
    cnt_next = cnt_reg;
    if (is_cmd) begin
      cnt_next = 16'd1;
    end else if (cnt_reg != 16'hFFFF) begin
      cnt_next = cnt_reg + 16'd1;
    end
  end

  always_comb begin
    state_next     = state_reg;
    init_done_next = init_done_reg;
    init_err_next  = init_err_reg;
    err_code_next  = err_code_reg;
    mode_reg_next  = mode_reg_reg;
    cas_lat_next   = cas_lat_reg;
    burst_len_next = burst_len_reg;
    aref_cnt_next  = aref_cnt_reg;
    fail           = 1'b0;
    fail_code      = 3'd0;

    case (state_reg)
      S_WAIT: begin
        if (is_cmd) begin
          if (cnt_reg < WAIT_MIN_C) begin
            fail = 1'b1; fail_code = E_EARLY;
          end else if (cmd_kind == C_PRE && sdram_addr[10]) begin
            state_next = S_TRP;
          end else begin
            fail = 1'b1; fail_code = E_ORDER;
          end
        end
      end
      S_TRP: begin
        if (is_cmd) begin
          if (cmd_kind != C_AREF) begin
            fail = 1'b1; fail_code = E_ORDER;
          end else if (cnt_reg < TRP_MIN_C) begin
            fail = 1'b1; fail_code = E_TRP;
          end else begin
            state_next    = S_AREF;
            aref_cnt_next = aref_cnt_reg + 4'd1;
          end
        end
      end
      S_AREF: begin
        if (is_cmd) begin
          if ((cmd_kind == C_AREF || cmd_kind == C_MRS) && cnt_reg < TRFC_MIN_C) begin
            fail = 1'b1; fail_code = E_TRFC;
          end else if (cmd_kind == C_AREF) begin
            if (aref_cnt_reg != 4'hF) aref_cnt_next = aref_cnt_reg + 4'd1;
          end else if (cmd_kind == C_MRS) begin
            if (aref_cnt_reg < AREF_MIN_C) begin
              fail = 1'b1; fail_code = E_ACNT;
            end else if (!mrs_ok) begin
              fail = 1'b1; fail_code = E_FIELD;
            end else begin
              state_next     = S_TMRD;
              mode_reg_next  = sdram_addr;
              cas_lat_next   = sdram_addr[6:4];
              burst_len_next = burst_decode(sdram_addr[2:0]);
            end
          end else begin
            fail = 1'b1; fail_code = E_ORDER;
          end
        end
      end
      S_TMRD: begin
        // Completion wins over a command landing on the same edge.
        if (cnt_reg >= TMRD_MIN_C) begin
          state_next     = S_DONE;
          init_done_next = 1'b1;
        end else if (is_cmd) begin
          fail = 1'b1; fail_code = E_TMRD;
        end
      end
      default: begin
        state_next = state_reg;
      end
    endcase

    if (fail) begin
      state_next    = S_ERR;
      init_err_next = 1'b1;
      err_code_next = fail_code;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg     <= S_WAIT;
      cnt_reg       <= 16'd0;
      init_done_reg <= 1'b0;
      init_err_reg  <= 1'b0;
      err_code_reg  <= 3'd0;
      mode_reg_reg  <= 13'd0;
      cas_lat_reg   <= 3'd0;
      burst_len_reg <= 4'd0;
      aref_cnt_reg  <= 4'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      init_done_reg <= init_done_next;
      init_err_reg  <= init_err_next;
      err_code_reg  <= err_code_next;
      mode_reg_reg  <= mode_reg_next;
      cas_lat_reg   <= cas_lat_next;
      burst_len_reg <= burst_len_next;
      aref_cnt_reg  <= aref_cnt_next;
    end
  end

  assign init_done = init_done_reg;
  assign init_err  = init_err_reg;
  assign err_code  = err_code_reg;
  assign mode_reg  = mode_reg_reg;
  assign cas_lat   = cas_lat_reg;
  assign burst_len = burst_len_reg;
  assign aref_cnt  = aref_cnt_reg;

endmodule

// File: tb/tb_sdram_init_chk.sv
// Scoreboard bench for sdram_init_chk: stimulus queues expected status, a monitor
// pops and compares on each status rise or on an explicit snapshot request.
module tb_sdram_init_chk;

  localparam int W = 2000;
  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] MRS  = 4'b0000;
  localparam logic [3:0] READ = 4'b0101;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [3:0]  sdram_cmd = NOP;
  logic [1:0]  sdram_ba = 2'b00;
  logic [12:0] sdram_addr = 13'd0;
  logic        init_done, init_err;
  logic [2:0]  err_code, cas_lat;
  logic [12:0] mode_reg;
  logic [3:0]  burst_len, aref_cnt;

  sdram_init_chk #(.WAIT_MIN(W)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .sdram_cmd  (sdram_cmd),
    .sdram_ba   (sdram_ba),
    .sdram_addr (sdram_addr),
    .init_done  (init_done),
    .init_err   (init_err),
    .err_code   (err_code),
    .mode_reg   (mode_reg),
    .cas_lat    (cas_lat),
    .burst_len  (burst_len),
    .aref_cnt   (aref_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc;
  always @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  typedef struct {
    string       name;
    bit          snap;
    int          cyc;
    logic        done;
    logic        err;
    logic [2:0]  code;
    logic [12:0] mode;
    logic [2:0]  cas;
    logic [3:0]  bl;
    logic [3:0]  aref;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic push(input string name, input bit snap, input int c,
                      input logic done, input logic err, input logic [2:0] code,
                      input logic [12:0] mode, input logic [2:0] cas,
                      input logic [3:0] bl, input logic [3:0] aref);
    exp_t e;
    e.name = name; e.snap = snap; e.cyc = c; e.done = done; e.err = err;
    e.code = code; e.mode = mode; e.cas = cas; e.bl = bl; e.aref = aref;
    sb.push_back(e);
  endtask

  // Monitor: compare on the falling edge, away from the sampling edge.
  logic [1:0] prev_status = 2'b00;
  always @(negedge sys_clk) begin
    logic [1:0] status;
    logic       rise;
    exp_t       e;
    status = {init_done, init_err};
    rise = ((status & ~prev_status) != 2'b00);
    prev_status = status;
    if (sb.size() > 0 && (sb[0].snap || rise)) begin
      e = sb.pop_front();
      n_tests++;
      if (init_done !== e.done || init_err !== e.err || err_code !== e.code ||
          mode_reg !== e.mode || cas_lat !== e.cas || burst_len !== e.bl ||
          aref_cnt !== e.aref || (e.cyc >= 0 && cyc != e.cyc)) begin
        n_fail++;
        $display("FAIL %s: got done=%0b err=%0b code=%0d mode=%h cas=%0d bl=%0d aref=%0d cyc=%0d; expected done=%0b err=%0b code=%0d mode=%h cas=%0d bl=%0d aref=%0d cyc=%0d",
                 e.name, init_done, init_err, err_code, mode_reg, cas_lat, burst_len, aref_cnt, cyc,
                 e.done, e.err, e.code, e.mode, e.cas, e.bl, e.aref, e.cyc);
      end else begin
        $display("[TB] ok %s (cyc=%0d code=%0d aref=%0d)", e.name, cyc, err_code, aref_cnt);
      end
    end else if (rise) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_status: got done=%0b err=%0b code=%0d at cyc=%0d, expected no change",
               init_done, init_err, err_code, cyc);
    end
  end

  task automatic step(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] addr);
    sdram_cmd = c; sdram_ba = ba; sdram_addr = addr;
    @(posedge sys_clk); #1;
    sdram_cmd = NOP; sdram_ba = 2'b00; sdram_addr = 13'd0;
  endtask

  task automatic nops(input int n);
    repeat (n) step(NOP, 2'b00, 13'd0);
  endtask

  task automatic wait_sb(input string name);
    int k = 0;
    while (sb.size() > 0 && k < 200) begin
      step(NOP, 2'b00, 13'd0);
      k++;
    end
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout_%s: got %0d pending expectations, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
  endtask

  task automatic legal_prefix(input int n_aref);
    nops(W + 1);
    step(PRE, 2'b00, 13'h1FFF);
    nops(3);
    for (int i = 0; i < n_aref; i++) begin
      step(AREF, 2'b00, 13'd0);
      nops(8);
    end
  endtask

  initial begin
    // Reset values
    push("reset_state", 1'b1, -1, 0, 0, 3'd0, 13'h0, 3'd0, 4'd0, 4'd0);
    wait_sb("reset_state");

    // Legal sequence: done two cycles after MRS, then frozen under normal traffic
    do_reset();
    push("legal_done", 1'b0, W + 80, 1, 0, 3'd0, 13'h0037, 3'd3, 4'd15, 4'd8);
    legal_prefix(8);
    step(MRS, 2'b00, 13'h0037);
    nops(3);
    wait_sb("legal_done");
    step(READ, 2'b00, 13'h0000);
    step(AREF, 2'b00, 13'h0000);
    step(MRS, 2'b00, 13'h0047);
    step(PRE, 2'b00, 13'h0000);
    nops(2);
    push("done_frozen", 1'b1, -1, 1, 0, 3'd0, 13'h0037, 3'd3, 4'd15, 4'd8);
    wait_sb("done_frozen");

    // Early PRECHARGE at distance 100
    do_reset();
    push("early_pre", 1'b0, 101, 0, 1, 3'd1, 13'h0, 3'd0, 4'd0, 4'd0);
    nops(100);
    step(PRE, 2'b00, 13'h1FFF);
    wait_sb("early_pre");

    // One cycle short of the wait
    do_reset();
    push("early_boundary", 1'b0, W, 0, 1, 3'd1, 13'h0, 3'd0, 4'd0, 4'd0);
    nops(W - 1);
    step(PRE, 2'b00, 13'h1FFF);
    wait_sb("early_boundary");

    // PRE exactly at the wait boundary is accepted; AREF one cycle later violates tRP
    do_reset();
    push("trp_violation", 1'b0, W + 2, 0, 1, 3'd3, 13'h0, 3'd0, 4'd0, 4'd0);
    nops(W);
    step(PRE, 2'b00, 13'h0400);
    step(AREF, 2'b00, 13'h0000);
    wait_sb("trp_violation");

    // Second AREF five cycles after the first
    do_reset();
    push("trfc_violation", 1'b0, W + 11, 0, 1, 3'd4, 13'h0, 3'd0, 4'd0, 4'd1);
    nops(W + 1);
    step(PRE, 2'b00, 13'h1FFF);
    nops(3);
    step(AREF, 2'b00, 13'h0000);
    nops(4);
    step(AREF, 2'b00, 13'h0000);
    wait_sb("trfc_violation");

    // Minimum legal spacings throughout, but only seven refreshes before MRS
    do_reset();
    push("aref_count", 1'b0, W + 52, 0, 1, 3'd5, 13'h0, 3'd0, 4'd0, 4'd7);
    nops(W);
    step(PRE, 2'b00, 13'h1FFF);
    nops(1);
    for (int i = 0; i < 7; i++) begin
      step(AREF, 2'b00, 13'h0000);
      nops(6);
    end
    step(MRS, 2'b00, 13'h0037);
    wait_sb("aref_count");

    // CAS latency 4 is rejected; later READ leaves the code untouched
    do_reset();
    push("mrs_field", 1'b0, W + 78, 0, 1, 3'd6, 13'h0, 3'd0, 4'd0, 4'd8);
    legal_prefix(8);
    step(MRS, 2'b00, 13'h0047);
    wait_sb("mrs_field");
    step(READ, 2'b00, 13'h0000);
    nops(2);
    push("err_sticky", 1'b1, -1, 0, 1, 3'd6, 13'h0, 3'd0, 4'd0, 4'd8);
    wait_sb("err_sticky");

    // PRECHARGE without the all-banks bit
    do_reset();
    push("pre_not_all", 1'b0, W + 2, 0, 1, 3'd2, 13'h0, 3'd0, 4'd0, 4'd0);
    nops(W + 1);
    step(PRE, 2'b00, 13'h1BFF);
    wait_sb("pre_not_all");

    // Command one cycle after MRS violates tMRD; mode already captured (CAS 2, BL 8)
    do_reset();
    push("tmrd_violation", 1'b0, W + 79, 0, 1, 3'd7, 13'h0023, 3'd2, 4'd8, 4'd8);
    legal_prefix(8);
    step(MRS, 2'b00, 13'h0023);
    step(AREF, 2'b00, 13'h0000);
    wait_sb("tmrd_violation");

    // Reset after the fourth refresh, then a full legal replay
    do_reset();
    legal_prefix(4);
    push("mid_aref4", 1'b1, -1, 0, 0, 3'd0, 13'h0, 3'd0, 4'd0, 4'd4);
    wait_sb("mid_aref4");
    sys_rst_n = 1'b0;
    push("mid_reset", 1'b1, -1, 0, 0, 3'd0, 13'h0, 3'd0, 4'd0, 4'd0);
    wait_sb("mid_reset");
    sys_rst_n = 1'b1;
    push("replay_done", 1'b0, W + 80, 1, 0, 3'd0, 13'h0037, 3'd3, 4'd15, 4'd8);
    legal_prefix(8);
    step(MRS, 2'b00, 13'h0037);
    nops(3);
    wait_sb("replay_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion by %0t, expected summary earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
